// File: rtl/dbguart_tx_arbiter.sv
// Line-granular arbiter sharing the debug UART transmit FIFO between text producers.
// Holds a grant until 0x0A, rotates fairly, and force-closes stalled or overlong lines.
module dbguart_tx_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 1023,
  parameter int MAXLEN  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              softreset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   grant,
  input  logic              tx_full,
  output logic              tx_write,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [7:0]        timeout_cnt
);

  localparam int OW = $clog2(NREQ);
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = $clog2(MAXLEN);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LEN_LAST  = LW'(MAXLEN - 2);
  localparam logic [7:0]    LF        = 8'h0A;

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [LW-1:0]   len_q, len_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      tcnt_q, tcnt_d;

  logic            pick_found;
  logic [OW-1:0]   pick_idx;
  int unsigned     scan;
  logic            own_valid;
  logic [7:0]      own_byte;
  logic            take;
  logic [OW-1:0]   next_rr;

  // Round-robin scan starting at rr_q, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan = 32'(rr_q) + i;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!pick_found && req_valid[scan]) begin
        pick_found = 1'b1;
        pick_idx   = OW'(scan);
      end
    end
  end

  assign own_valid = req_valid[owner_q];
  assign own_byte  = req_data[8*int'(owner_q) +: 8];
  assign take      = (state_q == ST_LOCK) && own_valid && !tx_full && !softreset;
  assign next_rr   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    idle_d   = idle_q;
    len_d    = len_q;
    grant_d  = grant_q;
    tcnt_d   = tcnt_q;
    req_ack  = '0;
    tx_write = 1'b0;
    tx_data  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_LOCK;
          owner_d = pick_idx;
          grant_d = NREQ'(1) << pick_idx;
          idle_d  = '0;
          len_d   = '0;
        end
      end
      ST_LOCK: begin
        if (take) begin
          req_ack[owner_q] = 1'b1;
          tx_write         = 1'b1;
          tx_data          = own_byte;
        end
        // A newline on the length boundary closes normally rather than flushing.
        if (take && own_byte == LF) begin
          state_d = ST_IDLE;
          rr_d    = next_rr;
          grant_d = '0;
        end else if (take && len_q == LEN_LAST) begin
          state_d = ST_FLUSH;
        end else if (take) begin
          len_d  = len_q + 1'b1;
          idle_d = '0;
        end else if (!own_valid) begin
          if (idle_q == IDLE_LAST) state_d = ST_FLUSH;
          else                     idle_d  = idle_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        tx_data  = LF;
        tx_write = !tx_full && !softreset;
        if (tx_write) begin
          state_d = ST_IDLE;
          rr_d    = next_rr;
          grant_d = '0;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (softreset) begin
      state_d = ST_IDLE;
      owner_d = '0;
      rr_d    = '0;
      idle_d  = '0;
      len_d   = '0;
      grant_d = '0;
      tcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      idle_q  <= '0;
      len_q   <= '0;
      grant_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      idle_q  <= idle_d;
      len_q   <= len_d;
      grant_q <= grant_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_dbguart_tx_arbiter.sv
// Scoreboard bench for dbguart_tx_arbiter: line-level reference model feeds
// expectation queues; a negedge monitor pops and compares.
module tb_dbguart_tx_arbiter;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 4;
  localparam int MAXLEN  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              softreset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   grant;
  logic              tx_full;
  logic              tx_write;
  logic [7:0]        tx_data;
  logic              busy;
  logic [7:0]        timeout_cnt;

  always #5 clk = ~clk;

  dbguart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst_n(rst_n), .softreset(softreset),
    .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .grant(grant), .tx_full(tx_full), .tx_write(tx_write), .tx_data(tx_data),
    .busy(busy), .timeout_cnt(timeout_cnt)
  );

  typedef struct {
    logic [NREQ-1:0] grant;
    logic            busy;
    logic [7:0]      tcnt;
    logic            wr;
    logic [NREQ-1:0] ack;
  } stat_t;
  typedef struct {
    logic [7:0]      data;
    logic [NREQ-1:0] ack;
  } wr_t;

  stat_t stat_q[$];
  wr_t   wr_q[$];
  logic [7:0]      act_bytes[$];
  logic [NREQ-1:0] act_ack[$];
  int              act_cyc[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit stepped = 0;
  bit rand_en = 0;
  int full_mode = 0;  // 0 never full, 1 always full, 2 random

  logic [7:0] pbuf [NREQ][512];
  int phead[NREQ];
  int ptail[NREQ];
  int pstall[NREQ];

  // Reference model: one open line at most, rotation start, bytes and idle streak.
  int m_owner, m_first, m_bytes, m_stall, m_forced;
  bit m_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_first = 0; m_bytes = 0; m_stall = 0; m_forced = 0; m_flush = 0;
  endtask

  task automatic model_release();
    m_first = (m_owner + 1) % NREQ;
    m_owner = -1;
    m_flush = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] v, input logic [8*NREQ-1:0] d,
                            input logic full, input logic sr, output logic [NREQ-1:0] ack);
    stat_t e;
    wr_t   w;
    logic [7:0] b;
    bit found;
    ack    = '0;
    e.grant = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    e.busy  = (m_owner >= 0);
    e.tcnt  = 8'(m_forced);
    e.wr    = 1'b0;
    e.ack   = '0;
    if (sr) begin
      // strobes suppressed; state cleared below
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int r;
        r = (m_first + k) % NREQ;
        if (!found && v[r]) begin
          found = 1; m_owner = r; m_bytes = 0; m_stall = 0;
        end
      end
    end else if (m_flush) begin
      if (!full) begin
        e.wr = 1'b1; w.data = 8'h0A; w.ack = '0; wr_q.push_back(w);
        m_forced = (m_forced < 255) ? m_forced + 1 : 255;
        model_release();
      end
    end else begin
      if (v[m_owner] && !full) begin
        b = d[8*m_owner +: 8];
        e.wr = 1'b1; e.ack[m_owner] = 1'b1; ack = e.ack;
        w.data = b; w.ack = e.ack; wr_q.push_back(w);
        if (b == 8'h0A) model_release();
        else if (m_bytes + 1 == MAXLEN - 1) m_flush = 1;
        else begin m_bytes++; m_stall = 0; end
      end else if (!v[m_owner]) begin
        m_stall++;
        if (m_stall == TIMEOUT) m_flush = 1;
      end
    end
    stat_q.push_back(e);
    if (sr) model_reset();
  endtask

  task automatic push_line(input int r, input string s);
    for (int k = 0; k < s.len(); k++) begin
      pbuf[r][ptail[r] % 512] = s[k];
      ptail[r]++;
    end
  endtask

  task automatic step();
    logic [NREQ-1:0]   v;
    logic [8*NREQ-1:0] d;
    logic [NREQ-1:0]   ack;
    logic              full, sr;
    @(posedge clk); #1;
    cyc++;
    for (int r = 0; r < NREQ; r++) begin
      bit en;
      en = 1;
      if (rand_en) begin
        if (pstall[r] > 0) begin pstall[r]--; en = 0; end
        else if ($urandom_range(0, 29) == 0) begin pstall[r] = $urandom_range(1, 6); en = 0; end
      end
      v[r] = (phead[r] < ptail[r]) && en;
      d[8*r +: 8] = (phead[r] < ptail[r]) ? pbuf[r][phead[r] % 512] : 8'($urandom);
    end
    full = (full_mode == 2) ? ($urandom_range(0, 4) == 0) : (full_mode == 1);
    sr   = rand_en && ($urandom_range(0, 599) == 0);
    req_valid = v; req_data = d; tx_full = full; softreset = sr;
    model_step(v, d, full, sr, ack);
    for (int r = 0; r < NREQ; r++) if (ack[r]) phead[r]++;
    stepped = 1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_write", tx_write, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tcnt", timeout_cnt, 0);
    stepped = 0;
    stat_q.delete(); wr_q.delete();
    for (int r = 0; r < NREQ; r++) begin phead[r] = ptail[r]; pstall[r] = 0; end
    req_valid = '0; softreset = 1'b0; tx_full = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    bool_loop: for (int i = 0; i < maxc; i++) begin
      bit pend;
      step();
      pend = 0;
      for (int r = 0; r < NREQ; r++) if (phead[r] < ptail[r]) pend = 1;
      if (m_owner < 0 && !pend) break;
      if (i == maxc - 1) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_timeout: line not drained after %0d cycles", name, maxc);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic expect_log(input int base, input string s, input string name);
    chk({name, "_len"}, act_bytes.size() - base, s.len());
    for (int k = 0; k < s.len(); k++)
      if (base + k < act_bytes.size()) chk(name, act_bytes[base + k], s[k]);
  endtask

  always @(negedge clk) begin
    if (rst_n && stepped) begin
      stepped = 0;
      chk("never_write_when_full", tx_write & tx_full, 0);
      if (stat_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL stat_queue: got empty expected entry");
      end else begin
        stat_t e;
        e = stat_q.pop_front();
        chk("grant", grant, e.grant);
        chk("busy", busy, e.busy);
        chk("timeout_cnt", timeout_cnt, e.tcnt);
        chk("tx_write", tx_write, e.wr);
        chk("req_ack", req_ack, e.ack);
      end
      if (tx_write) begin
        act_bytes.push_back(tx_data); act_ack.push_back(req_ack); act_cyc.push_back(cyc);
        if (wr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got %0h expected none", tx_data);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("tx_data", tx_data, w.data);
          chk("write_ack", req_ack, w.ack);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; softreset = 1'b0; req_valid = '0; req_data = '0; tx_full = 1'b0;
    for (int r = 0; r < NREQ; r++) begin phead[r] = 0; ptail[r] = 0; pstall[r] = 0; end
    model_reset();
    #1;
    chk("init_grant", grant, 0);
    chk("init_busy", busy, 0);
    chk("init_tx_write", tx_write, 0);
    chk("init_tcnt", timeout_cnt, 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

    // Single line "AB\n" from requester 0.
    base = act_bytes.size();
    push_line(0, "AB\n");
    step();
    step();
    chk("t1_grant_next_cycle", grant, 3'b001);
    wait_idle(20, "t1");
    expect_log(base, "AB\n", "t1_bytes");
    if (act_bytes.size() >= base + 3) chk("t1_consecutive", act_cyc[base + 2] - act_cyc[base], 2);
    chk("t1_tcnt", timeout_cnt, 0);

    // rr_ptr is now 1: requester 1 beats requester 0.
    base = act_bytes.size();
    push_line(0, "a\n"); push_line(1, "b\n");
    wait_idle(20, "t1b");
    expect_log(base, "b\na\n", "t1b_bytes");
    if (act_ack.size() >= base + 3) chk("t1b_first_owner", act_ack[base], 3'b010);

    // Requesters 0 and 2 from reset.
    do_reset();
    base = act_bytes.size();
    push_line(0, "x\n"); push_line(2, "x\n");
    wait_idle(20, "t2");
    expect_log(base, "x\nx\n", "t2_bytes");
    if (act_ack.size() >= base + 4) begin
      chk("t2_owner_a", act_ack[base], 3'b001);
      chk("t2_owner_b", act_ack[base + 2], 3'b100);
      chk("t2_gap", act_cyc[base + 2] - act_cyc[base + 1], 2);
    end

    // Owner 1 stalls after "Q": forced newline after TIMEOUT idle cycles.
    do_reset();
    base = act_bytes.size();
    push_line(1, "Q"); push_line(2, "z\n");
    wait_idle(40, "t3");
    expect_log(base, "Q\nz\n", "t3_bytes");
    if (act_ack.size() >= base + 4) begin
      chk("t3_flush_ack", act_ack[base + 1], 0);
      chk("t3_flush_delay", act_cyc[base + 1] - act_cyc[base], 5);
      chk("t3_next_owner", act_ack[base + 2], 3'b100);
    end
    chk("t3_tcnt", timeout_cnt, 1);

    // MAXLEN split, then a newline landing exactly on the boundary.
    do_reset();
    base = act_bytes.size();
    push_line(0, "abcde\n");
    wait_idle(40, "t4");
    expect_log(base, "abc\nde\n", "t4_bytes");
    chk("t4_tcnt", timeout_cnt, 1);

    // Back-pressure for 10 cycles mid-line is not a stall.
    base = act_bytes.size();
    push_line(0, "mn\n");
    step(); step();
    full_mode = 1;
    repeat (10) step();
    full_mode = 0;
    wait_idle(20, "t5");
    expect_log(base, "mn\n", "t5_bytes");
    if (act_cyc.size() >= base + 2) chk("t5_resume", act_cyc[base + 1] - act_cyc[base], 11);
    chk("t5_tcnt", timeout_cnt, 1);

    // Async reset mid-line; arbitration restarts from requester 0.
    base = act_bytes.size();
    push_line(1, "k\n");
    wait_idle(20, "t6a");
    push_line(0, "wx");
    step(); step(); step(); step();
    expect_log(base, "k\nwx", "t6_before");
    do_reset();
    base = act_bytes.size();
    push_line(0, "r\n"); push_line(2, "s\n");
    wait_idle(20, "t6");
    expect_log(base, "r\ns\n", "t6_after");

    // Randomized traffic with back-pressure, stalls and soft resets.
    rand_en = 1; full_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (ptail[r] - phead[r] < 8 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(0, 5);
          for (int k = 0; k < len; k++) begin
            pbuf[r][ptail[r] % 512] = 8'($urandom_range(8'h20, 8'h7E));
            ptail[r]++;
          end
          if ($urandom_range(0, 9) != 0) begin
            pbuf[r][ptail[r] % 512] = 8'h0A;
            ptail[r]++;
          end
        end
      end
      step();
    end
    rand_en = 0; full_mode = 0;
    for (int r = 0; r < NREQ; r++) pstall[r] = 0;
    wait_idle(400, "rand_drain");
    chk("wr_queue_drained", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
